// File: rtl/product_sat_pkg.sv
// Shared constants and helpers for the pipelined saturating multiplier.
// Covers the pipeline latency, the shift-port width and the saturation limits.
package product_sat_pkg;

    localparam int LATENCY = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((longint'(1) << r) < longint'(value)) r++;
        return r;
    endfunction

    // The shift port must hold every value 0..SHIFT_MAX and is never narrower than 1 bit.
    function automatic int shift_width(input int shift_max);
        int w;
        w = clog2(shift_max + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic longint sat_max(input int bits_out);
        return (longint'(1) << (bits_out - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int bits_out);
        return -(longint'(1) << (bits_out - 1));
    endfunction

endpackage

// File: rtl/red_pitaya_product_sat_pipe_if.sv
// Beat bus for red_pitaya_product_sat_pipe. All lanes share one valid.
// valid_i qualifies every lane of a beat. There is no ready: the pipe accepts one beat on every clock.
interface red_pitaya_product_sat_pipe_if
    import product_sat_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int BITS_IN1  = 14,
    parameter int BITS_IN2  = 14,
    parameter int BITS_OUT  = 14,
    parameter int SHIFT_MAX = 16,
    parameter int CNT_BITS  = 16
);
    localparam int SW = shift_width(SHIFT_MAX);

    logic                     valid_i;
    logic [NCH*BITS_IN1-1:0]  factor1_i;
    logic [NCH*BITS_IN2-1:0]  factor2_i;
    logic [SW-1:0]            shift_i;
    logic                     ovf_clr_i;
    logic                     valid_o;
    logic [NCH*BITS_OUT-1:0]  product_o;
    logic [NCH-1:0]           overflow_o;
    logic [NCH-1:0]           ovf_sticky_o;
    logic [CNT_BITS-1:0]      ovf_cnt_o;

    modport master (
        output valid_i, factor1_i, factor2_i, shift_i, ovf_clr_i,
        input  valid_o, product_o, overflow_o, ovf_sticky_o, ovf_cnt_o
    );

    modport slave (
        input  valid_i, factor1_i, factor2_i, shift_i, ovf_clr_i,
        output valid_o, product_o, overflow_o, ovf_sticky_o, ovf_cnt_o
    );

endinterface

// File: rtl/red_pitaya_product_sat_lane.sv
// One lane of the S1..S3 datapath: register factors, multiply, shift, optionally round, saturate.
// When PRODUCT_SAT_ROUND_EN is defined, the shift rounds half up. Otherwise it truncates toward -inf.
module red_pitaya_product_sat_lane
    import product_sat_pkg::*;
#(
    parameter int BITS_IN1 = 14,
    parameter int BITS_IN2 = 14,
    parameter int BITS_OUT = 14,
    parameter int SW       = 5
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                s1_en_i,
    input  logic                s2_en_i,
    input  logic                s3_en_i,
    input  logic [BITS_IN1-1:0] factor1_i,
    input  logic [BITS_IN2-1:0] factor2_i,
    input  logic [SW-1:0]       sh_i,
    output logic [BITS_OUT-1:0] product_o,
    output logic                overflow_o,
    output logic                ev_o
);
    localparam int W = BITS_IN1 + BITS_IN2;

    localparam logic signed [W:0]          LIM_HI = (W+1)'(sat_max(BITS_OUT));
    localparam logic signed [W:0]          LIM_LO = (W+1)'(sat_min(BITS_OUT));
    localparam logic signed [BITS_OUT-1:0] OUT_HI = LIM_HI[BITS_OUT-1:0];
    localparam logic signed [BITS_OUT-1:0] OUT_LO = LIM_LO[BITS_OUT-1:0];

    logic signed [BITS_IN1-1:0] f1_q;
    logic signed [BITS_IN2-1:0] f2_q;
    logic signed [W-1:0]        p_q, p_d;
    logic signed [W:0]          ext;
    logic signed [W:0]          shifted;
    logic        [BITS_OUT-1:0] sat_d, product_q;
    logic                       ovf_d, ovf_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            f1_q      <= '0;
            f2_q      <= '0;
            p_q       <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (s1_en_i) begin
                f1_q <= factor1_i;
                f2_q <= factor2_i;
            end
            if (s2_en_i) p_q <= p_d;
            if (s3_en_i) product_q <= sat_d;
            ovf_q <= s3_en_i & ovf_d;
        end
    end

    always_comb p_d = f1_q * f2_q;

`ifdef PRODUCT_SAT_ROUND_EN
    localparam logic signed [W:0] ONE = (W+1)'(1);
    logic signed [W:0] rnd;

    // One spare bit keeps the half-LSB addition from wrapping at the positive extreme.
    always_comb begin
        ext = {p_q[W-1], p_q};
        rnd = '0;
        if (sh_i != '0) rnd = ONE <<< (sh_i - SW'(1));
        shifted = (ext + rnd) >>> sh_i;
    end
`else
    always_comb begin
        ext     = {p_q[W-1], p_q};
        shifted = ext >>> sh_i;
    end
`endif

    always_comb begin
        sat_d = shifted[BITS_OUT-1:0];
        ovf_d = 1'b0;
        if (shifted > LIM_HI) begin
            sat_d = OUT_HI;
            ovf_d = 1'b1;
        end else if (shifted < LIM_LO) begin
            sat_d = OUT_LO;
            ovf_d = 1'b1;
        end
    end

    assign product_o  = product_q;
    assign overflow_o = ovf_q;
    assign ev_o       = s3_en_i & ovf_d;

endmodule

// File: rtl/red_pitaya_product_sat_pipe.sv
// NCH-lane 3-stage saturating multiplier with a shared run-time shift and overflow bookkeeping.
// When PRODUCT_SAT_ROUND_EN is defined, the lanes round half up instead of truncating.
module red_pitaya_product_sat_pipe
    import product_sat_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int BITS_IN1  = 14,
    parameter int BITS_IN2  = 14,
    parameter int BITS_OUT  = 14,
    parameter int SHIFT_MAX = 16,
    parameter int CNT_BITS  = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    red_pitaya_product_sat_pipe_if.slave  bus
);
    localparam int                  SW      = shift_width(SHIFT_MAX);
    localparam logic [SW-1:0]       SH_MAX  = SW'(SHIFT_MAX);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [LATENCY-1:0]  vld_q;
    logic [SW-1:0]       sh_clamp;
    logic [SW-1:0]       sh1_q, sh2_q;
    logic [NCH-1:0]      ev;
    logic                ev_any;
    logic [NCH-1:0]      sticky_q, sticky_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    always_comb sh_clamp = (bus.shift_i > SH_MAX) ? SH_MAX : bus.shift_i;

    // The valid chain runs every cycle. The shift follows its beat and loads only with valid.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_q <= '0;
            sh1_q <= '0;
            sh2_q <= '0;
        end else begin
            vld_q <= {vld_q[LATENCY-2:0], bus.valid_i};
            if (bus.valid_i) sh1_q <= sh_clamp;
            if (vld_q[0])    sh2_q <= sh1_q;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        red_pitaya_product_sat_lane #(
            .BITS_IN1 (BITS_IN1),
            .BITS_IN2 (BITS_IN2),
            .BITS_OUT (BITS_OUT),
            .SW       (SW)
        ) u_lane (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .s1_en_i    (bus.valid_i),
            .s2_en_i    (vld_q[0]),
            .s3_en_i    (vld_q[1]),
            .factor1_i  (bus.factor1_i[k*BITS_IN1 +: BITS_IN1]),
            .factor2_i  (bus.factor2_i[k*BITS_IN2 +: BITS_IN2]),
            .sh_i       (sh2_q),
            .product_o  (bus.product_o[k*BITS_OUT +: BITS_OUT]),
            .overflow_o (bus.overflow_o[k]),
            .ev_o       (ev[k])
        );
    end

    assign ev_any = |ev;

    // A clear keeps the event that lands in the same cycle, so no overflow is ever lost.
    always_comb begin
        sticky_d = bus.ovf_clr_i ? ev : (sticky_q | ev);
        cnt_d    = cnt_q;
        if (bus.ovf_clr_i)
            cnt_d = ev_any ? CNT_BITS'(1) : '0;
        else if (ev_any && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_BITS'(1);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.valid_o      = vld_q[LATENCY-1];
    assign bus.ovf_sticky_o = sticky_q;
    assign bus.ovf_cnt_o    = cnt_q;

endmodule
